// File: rtl/cache_ctrl_dm.sv
// cache_ctrl_dm: direct-mapped, write-back, write-allocate cache controller.
// It drives a single cacheway (a data array with a 1-cycle registered read,
// and a tag array with a combinational read) and the main-memory bus.
// Tag word in the way: {valid, dirty, addr_tag}.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   a, d, rd, we        CPU word address / write data / read, write request
//   spo, ready          CPU read data / one-cycle completion pulse
//   mem_a, mem_d        memory word address / write data
//   mem_rd, mem_we      memory request, held until mem_ready
//   mem_spo, mem_ready  memory read data / completion pulse
//   way_en, way_we      way enable / data write enable
//   way_a, way_d        way address / write data
//   way_spo             way read data (registered)
//   way_tag_we          way tag write enable
//   way_tag_in          tag to store
//   way_tag_out         tag at the index of way_a
//   way_init_done       way tag sweep finished
//
// Optional feature, enabled by defining CACHE_STATS_EN:
//   hit_cnt, miss_cnt   first-lookup hit/miss counters (replays not counted)
//
// State     | meaning
// ----------+-----------------------------------------------------------
// S_INIT    | waiting for the way to finish clearing its tags
// S_IDLE    | waiting for a CPU request; the request gets latched here
// S_LOOKUP  | tag compare; a write hit updates data and sets dirty
// S_RESP    | ready pulse, read data returned from the way
// S_WB_RD   | reading victim word i from the way
// S_WB_WR   | writing victim word i to memory
// S_FILL    | reading word i from memory into the way
module cache_ctrl_dm #(
  parameter int LINES           = 128,
  parameter int WORDS_PER_BLOCK = 32,
  parameter int TAG_LENGTH      = 32 - 2 - $clog2(WORDS_PER_BLOCK) - $clog2(LINES) + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           a,
  input  logic [31:0]           d,
  input  logic                  rd,
  input  logic                  we,
  output logic [31:0]           spo,
  output logic                  ready,
  output logic [31:0]           mem_a,
  output logic [31:0]           mem_d,
  output logic                  mem_rd,
  output logic                  mem_we,
  input  logic [31:0]           mem_spo,
  input  logic                  mem_ready,
  output logic                  way_en,
  output logic                  way_we,
  output logic [31:0]           way_a,
  output logic [31:0]           way_d,
  input  logic [31:0]           way_spo,
  output logic                  way_tag_we,
  output logic [TAG_LENGTH-1:0] way_tag_in,
  input  logic [TAG_LENGTH-1:0] way_tag_out,
  input  logic                  way_init_done
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  localparam int OFF_W  = $clog2(WORDS_PER_BLOCK);
  localparam int IDX_W  = $clog2(LINES);
  localparam int ATAG_W = TAG_LENGTH - 2;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LOOKUP, S_RESP, S_WB_RD, S_WB_WR, S_FILL
  } state_t;

  state_t            state_q, state_d;
  logic [ATAG_W-1:0] atag_q, old_tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [OFF_W-1:0]  off_q;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       d_q;
  logic              wr_q;

  logic tag_valid, tag_dirty, hit, last_word;
  logic unused_addr_bits;

  // Byte-lane bits of the CPU address carry no information for word access.
  assign unused_addr_bits = ^a[1:0];

  assign tag_valid = way_tag_out[TAG_LENGTH-1];
  assign tag_dirty = way_tag_out[TAG_LENGTH-2];
  assign hit       = tag_valid && (way_tag_out[ATAG_W-1:0] == atag_q);
  assign last_word = (cnt_q == '1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  // Next-state logic (also steps the line word counter)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT:   if (way_init_done) state_d = S_IDLE;
      S_IDLE:   if (rd || we) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (hit)                         state_d = S_RESP;
        else if (tag_valid && tag_dirty) state_d = S_WB_RD;
        else                             state_d = S_FILL;
      end
      S_RESP:   state_d = S_IDLE;
      S_WB_RD:  state_d = S_WB_WR;
      S_WB_WR: begin
        if (mem_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = last_word ? S_FILL : S_WB_RD;
        end
      end
      S_FILL: begin
        if (mem_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (last_word) state_d = S_LOOKUP;
        end
      end
      default:  state_d = S_INIT;
    endcase
  end

  // Output logic
  always_comb begin
    ready      = 1'b0;
    spo        = '0;
    mem_a      = '0;
    mem_d      = '0;
    mem_rd     = 1'b0;
    mem_we     = 1'b0;
    way_en     = (state_q != S_INIT);
    way_we     = 1'b0;
    way_a      = {atag_q, idx_q, off_q, 2'b00};
    way_d      = d_q;
    way_tag_we = 1'b0;
    way_tag_in = {1'b1, 1'b1, atag_q};
    case (state_q)
      // Present the raw request address so the tag is ready next cycle.
      S_IDLE:   way_a = {a[31:2], 2'b00};
      S_LOOKUP: begin
        if (hit && wr_q) begin
          way_we     = 1'b1;
          way_tag_we = 1'b1;
        end
      end
      S_RESP: begin
        ready = 1'b1;
        if (!wr_q) spo = way_spo;
      end
      S_WB_RD:  way_a = {atag_q, idx_q, cnt_q, 2'b00};
      S_WB_WR: begin
        // way_a is held, so way_spo stays on word i for the whole transfer.
        way_a  = {atag_q, idx_q, cnt_q, 2'b00};
        mem_we = 1'b1;
        mem_a  = {old_tag_q, idx_q, cnt_q, 2'b00};
        mem_d  = way_spo;
      end
      S_FILL: begin
        way_a  = {atag_q, idx_q, cnt_q, 2'b00};
        way_d  = mem_spo;
        mem_rd = 1'b1;
        mem_a  = {atag_q, idx_q, cnt_q, 2'b00};
        if (mem_ready) begin
          way_we = 1'b1;
          if (last_word) begin
            way_tag_we = 1'b1;
            way_tag_in = {1'b1, 1'b0, atag_q};
          end
        end
      end
      default: ;
    endcase
  end

  // Request latch, victim tag and line word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      atag_q    <= '0;
      idx_q     <= '0;
      off_q     <= '0;
      d_q       <= '0;
      wr_q      <= 1'b0;
      old_tag_q <= '0;
      cnt_q     <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (state_q == S_IDLE && (rd || we)) begin
        atag_q <= a[31:IDX_W+OFF_W+2];
        idx_q  <= a[IDX_W+OFF_W+1:OFF_W+2];
        off_q  <= a[OFF_W+1:2];
        d_q    <= d;
        wr_q   <= we;
      end
      if (state_q == S_LOOKUP) old_tag_q <= way_tag_out[ATAG_W-1:0];
    end
  end

`ifdef CACHE_STATS_EN
  logic        replay_q;
  logic [31:0] hit_q, miss_q;

  // The lookup after a refill is a replay and is not counted again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      replay_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      if (state_q == S_FILL && state_d == S_LOOKUP) replay_q <= 1'b1;
      else if (state_q == S_IDLE)                   replay_q <= 1'b0;
      if (state_q == S_LOOKUP && !replay_q) begin
        if (hit) hit_q  <= hit_q + 32'd1;
        else     miss_q <= miss_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`endif

endmodule
